// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS pipeline front end: machine word, next-PC select
// codes and fetch FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PC4    = 2'd0,
        JUMP   = 2'd1,
        JR     = 2'd2,
        BRANCH = 2'd3
    } pcsel_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of icache, hazard-unit and decode-side signals around the fetch stage.
// Optional FETCH_STATS_EN adds the stall/redirect counters.
interface fetch_stage_if;
    logic        ihit;
    logic [31:0] iload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        pcen;
    logic        deen;
    logic        deflush;
    logic [1:0]  PCSel;
    logic [25:0] jaddr;
    logic [31:0] jraddr;
    logic [31:0] baddr;
    logic        halt;
    logic [31:0] de_instr;
    logic [31:0] de_pcplus4;
    logic        de_valid;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] redir_cnt;
`endif

    // The fetch stage itself.
    modport master (
        input  ihit, iload, pcen, deen, deflush, PCSel, jaddr, jraddr, baddr, halt,
`ifdef FETCH_STATS_EN
        output stall_cnt, redir_cnt,
`endif
        output imemREN, imemaddr, de_instr, de_pcplus4, de_valid, halted
    );

    // The surrounding pipeline (icache, hazard unit, decode).
    modport slave (
        output ihit, iload, pcen, deen, deflush, PCSel, jaddr, jraddr, baddr, halt,
`ifdef FETCH_STATS_EN
        input  stall_cnt, redir_cnt,
`endif
        input  imemREN, imemaddr, de_instr, de_pcplus4, de_valid, halted
    );
endinterface

// File: rtl/fetch_target_sel.sv
// Combinational next-PC selection: PC+4, jump, jr or branch target.
module fetch_target_sel
    import cpu_types_pkg::*;
(
    input  word_t       pc,
    input  pcsel_t      pcsel,
    input  logic [25:0] jaddr,
    input  word_t       jraddr,
    input  word_t       baddr,
    input  logic [3:0]  de_region,   // de_pcplus4[31:28], the jump region
    output word_t       target
);

    always_comb begin
        // NOTE: assign a default first so no path through the case infers a latch.
        target = pc + PC_STEP;
        case (pcsel)
            PC4:     target = pc + PC_STEP;
            JUMP:    target = {de_region, jaddr, 2'b00};
            JR:      target = jraddr;
            BRANCH:  target = baddr;
            default: target = pc + PC_STEP;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, icache request, IF/ID latch and the
// stalled-redirect FSM. Define FETCH_STATS_EN for stall/redirect counters.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master bus
);

    fetch_state_t state;
    word_t        pc;
    word_t        redir_q;
    word_t        target;
    word_t        de_instr_q;
    word_t        de_pcplus4_q;
    logic         de_valid_q;
    logic         halted_q;
    logic         imem_ren_q;
    pcsel_t       sel;

    assign sel = pcsel_t'(bus.PCSel);

    fetch_target_sel u_target_sel (
        .pc        (pc),
        .pcsel     (sel),
        .jaddr     (bus.jaddr),
        .jraddr    (bus.jraddr),
        .baddr     (bus.baddr),
        .de_region (de_pcplus4_q[31:28]),
        .target    (target)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RUN;
            pc         <= RESET_PC;
            redir_q    <= '0;
            halted_q   <= 1'b0;
            imem_ren_q <= 1'b1;
        end else if (bus.halt) begin
            state      <= HALTED;
            halted_q   <= 1'b1;
            imem_ren_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.pcen) begin
                        pc <= target;
                    end else if (sel != PC4) begin
                        redir_q <= target;
                        state   <= PEND;
                    end
                end
                PEND: begin
                    if (bus.pcen) begin
                        pc    <= (sel != PC4) ? target : redir_q;
                        state <= RUN;
                    end else if (sel != PC4) begin
                        redir_q <= target;
                    end
                end
                default: ;   // HALTED: frozen until reset
            endcase
        end
    end

    // IF/ID latch; frozen once halted, and a retiring halt blocks new loads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            de_instr_q   <= '0;
            de_pcplus4_q <= '0;
            de_valid_q   <= 1'b0;
        end else if (state != HALTED) begin
            if (bus.deflush) begin
                de_instr_q <= '0;
                de_valid_q <= 1'b0;
            end else if (bus.deen && !bus.halt) begin
                de_instr_q   <= bus.iload;
                de_pcplus4_q <= pc + PC_STEP;
                de_valid_q   <= bus.ihit;
            end
        end
    end

    assign bus.imemREN    = imem_ren_q;
    assign bus.imemaddr   = pc;
    assign bus.halted     = halted_q;
    assign bus.de_instr   = de_instr_q;
    assign bus.de_pcplus4 = de_pcplus4_q;
    assign bus.de_valid   = de_valid_q;

`ifdef FETCH_STATS_EN
    word_t stall_cnt_q;
    word_t redir_cnt_q;
    logic  redir_apply;

    assign redir_apply = !bus.halt && bus.pcen &&
                         ((state == RUN && sel != PC4) || state == PEND);

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (imem_ren_q && !bus.ihit) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redir_apply)             redir_cnt_q <= redir_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.redir_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a table of single-cycle vectors plus
// hand-written multi-cycle sequences for stalls, PEND, halt and reset.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic CLK;
    logic RST;
    int   n_cmp;
    int   n_fail;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        pcen;
        logic        deen;
        logic        deflush;
        logic [1:0]  sel;
        logic        ihit;
        logic [31:0] iload;
        logic [25:0] jaddr;
        logic [31:0] jraddr;
        logic [31:0] baddr;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic pcen, input logic deen, input logic deflush,
                          input logic [1:0] sel, input logic ihit, input logic halt);
        bus.pcen    = pcen;
        bus.deen    = deen;
        bus.deflush = deflush;
        bus.PCSel   = sel;
        bus.ihit    = ihit;
        bus.halt    = halt;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        step();
        step();
        RST = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        bus.iload  = '0;
        bus.jaddr  = '0;
        bus.jraddr = '0;
        bus.baddr  = '0;

        //           pcen deen fl  sel  ihit iload         jaddr         jraddr        baddr         e_addr        e_instr       e_pc4         e_valid
        vecs[0]  = '{1'b1,1'b1,1'b0,2'd0,1'b1,32'hA000_0000,26'h0,        32'h0,        32'h0,        32'h0000_0004,32'hA000_0000,32'h0000_0004,1'b1};
        vecs[1]  = '{1'b1,1'b1,1'b0,2'd0,1'b1,32'hA000_0001,26'h0,        32'h0,        32'h0,        32'h0000_0008,32'hA000_0001,32'h0000_0008,1'b1};
        vecs[2]  = '{1'b1,1'b1,1'b0,2'd0,1'b1,32'hA000_0002,26'h0,        32'h0,        32'h0,        32'h0000_000C,32'hA000_0002,32'h0000_000C,1'b1};
        vecs[3]  = '{1'b1,1'b1,1'b1,2'd3,1'b1,32'hA000_0003,26'h0,        32'h0,        32'h0000_0100,32'h0000_0100,32'h0,        32'h0000_000C,1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b0,2'd0,1'b0,32'hA000_0004,26'h0,        32'h0,        32'h0,        32'h0000_0104,32'hA000_0004,32'h0000_0104,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,2'd0,1'b1,32'hA000_0005,26'h0,        32'h0,        32'h0,        32'h0000_0104,32'hA000_0004,32'h0000_0104,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b0,2'd2,1'b1,32'hA000_0006,26'h0,        32'h1234_5678,32'h0,        32'h1234_5678,32'hA000_0006,32'h0000_0108,1'b1};
        vecs[7]  = '{1'b1,1'b0,1'b0,2'd1,1'b1,32'hA000_0007,26'h3FF_FFFF, 32'h0,        32'h0,        32'h0FFF_FFFC,32'hA000_0006,32'h0000_0108,1'b1};
        vecs[8]  = '{1'b1,1'b1,1'b0,2'd0,1'b1,32'hA000_0008,26'h0,        32'h0,        32'h0,        32'h1000_0000,32'hA000_0008,32'h1000_0000,1'b1};
        vecs[9]  = '{1'b1,1'b0,1'b0,2'd2,1'b1,32'hA000_0009,26'h0,        32'hFFFF_FFFC,32'h0,        32'hFFFF_FFFC,32'hA000_0008,32'h1000_0000,1'b1};
        vecs[10] = '{1'b1,1'b1,1'b0,2'd0,1'b1,32'hA000_000A,26'h0,        32'h0,        32'h0,        32'h0000_0000,32'hA000_000A,32'h0000_0000,1'b1};

        do_reset();
        check("rst_imemaddr",   bus.imemaddr,   32'h0);
        check("rst_de_instr",   bus.de_instr,   32'h0);
        check("rst_de_pcplus4", bus.de_pcplus4, 32'h0);
        check("rst_de_valid",   {31'b0, bus.de_valid}, 32'd0);
        check("rst_halted",     {31'b0, bus.halted},   32'd0);
        check("rst_imemREN",    {31'b0, bus.imemREN},  32'd1);

        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i].pcen, vecs[i].deen, vecs[i].deflush, vecs[i].sel, vecs[i].ihit, 1'b0);
            bus.iload  = vecs[i].iload;
            bus.jaddr  = vecs[i].jaddr;
            bus.jraddr = vecs[i].jraddr;
            bus.baddr  = vecs[i].baddr;
            step();
            check($sformatf("v%0d_imemaddr", i),   bus.imemaddr,   vecs[i].e_addr);
            check($sformatf("v%0d_de_instr", i),   bus.de_instr,   vecs[i].e_instr);
            check($sformatf("v%0d_de_pcplus4", i), bus.de_pcplus4, vecs[i].e_pc4);
            check($sformatf("v%0d_de_valid", i),   {31'b0, bus.de_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d_imemREN", i),    {31'b0, bus.imemREN},  32'd1);
        end

        // Redirect held across a 3-cycle stall.
        bus.jraddr = 32'h4000_000C;
        set_in(1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);
        step();
        bus.iload = 32'hCAFE_0001;
        set_in(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        step();
        check("stall_setup_pc4", bus.de_pcplus4, 32'h4000_0010);
        bus.jaddr = 26'h40;
        set_in(1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d_pc_hold", i), bus.imemaddr, 32'h4000_0010);
        end
        set_in(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        step();
        check("pend_jump_target", bus.imemaddr, 32'h4000_0100);

        // Newest redirect wins while pending.
        bus.jraddr = 32'h200;
        set_in(1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);
        step();
        check("pend_jr_hold", bus.imemaddr, 32'h4000_0100);
        bus.baddr = 32'h300;
        set_in(1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0);
        step();
        set_in(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        step();
        check("pend_overwrite", bus.imemaddr, 32'h300);

        // Live redirect on the releasing cycle beats the stored one.
        bus.jraddr = 32'h500;
        set_in(1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);
        step();
        bus.baddr = 32'h600;
        set_in(1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0);
        step();
        check("pend_live_target", bus.imemaddr, 32'h600);
        set_in(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        step();
        check("back_to_run", bus.imemaddr, 32'h604);

        // Halt beats a simultaneous branch and latch load, then freezes.
        bus.baddr = 32'h700;
        bus.iload = 32'hDEAD_BEEF;
        set_in(1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1);
        step();
        check("halt_halted",   {31'b0, bus.halted},  32'd1);
        check("halt_imemREN",  {31'b0, bus.imemREN}, 32'd0);
        check("halt_pc_hold",  bus.imemaddr,   32'h604);
        check("halt_pc4_hold", bus.de_pcplus4, 32'h4000_0010);
        set_in(1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
        step();
        step();
        check("halted_pc_frozen",    bus.imemaddr, 32'h604);
        check("halted_instr_frozen", bus.de_instr, 32'hCAFE_0001);
        check("halted_still",        {31'b0, bus.halted}, 32'd1);
        do_reset();
        check("halt_rst_addr",    bus.imemaddr, 32'h0);
        check("halt_rst_halted",  {31'b0, bus.halted},  32'd0);
        check("halt_rst_imemREN", {31'b0, bus.imemREN}, 32'd1);

        // Reset while pending discards the stored redirect.
        bus.jaddr = 26'h10;
        set_in(1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0);
        step();
        do_reset();
        set_in(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        step();
        check("rst_pend_discard", bus.imemaddr, 32'h4);

`ifdef FETCH_STATS_EN
        do_reset();
        check("stats_rst_stall", bus.stall_cnt, 32'd0);
        check("stats_rst_redir", bus.redir_cnt, 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        bus.baddr = 32'h80;
        set_in(1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0);
        step();
        check("stats_stall_cnt", bus.stall_cnt, 32'd5);
        check("stats_redir_cnt", bus.redir_cnt, 32'd1);
        check("stats_addr",      bus.imemaddr,  32'h80);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
